// File: rtl/multdiv_seq.sv
// Control sequencer for the 66-bit multiply/divide register: radix-2 Booth
// multiplication and non-restoring division, one datapath step per operand bit.
module multdiv_seq #(
  parameter int unsigned STEPS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       divisor_zero,
  input  logic [1:0] booth_bits,
  input  logic       rem_neg,
  output logic       reg_en,
  output logic [1:0] reg_sel,
  output logic [1:0] alu_op,
  output logic       is_div,
  output logic       busy,
  output logic [5:0] step_cnt,
  output logic       data_resultRDY,
  output logic       data_exception
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_STEP = 2'b10;
  localparam logic [1:0] SEL_FIX  = 2'b11;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);
  localparam logic [5:0] MAX_CNT   = 6'(STEPS);

  state_t state;
  state_t nxt;
  logic   nxt_div;
  logic   nxt_exc;
  logic   exc_q;
  logic   busy_n;
  logic   start;

  assign start = ctrl_MULT | ctrl_DIV;

  // A start pulse in any state aborts and re-decodes; multiply has priority.
  always_comb begin
    nxt     = state;
    nxt_div = is_div;
    nxt_exc = exc_q;
    if (ctrl_MULT) begin
      nxt     = S_LOAD;
      nxt_div = 1'b0;
      nxt_exc = 1'b0;
    end else if (ctrl_DIV) begin
      nxt     = divisor_zero ? S_DONE : S_LOAD;
      nxt_div = ~divisor_zero;
      nxt_exc = divisor_zero;
    end else begin
      case (state)
        S_IDLE:  nxt = S_IDLE;
        S_LOAD:  nxt = S_STEP;
        S_STEP:  if (step_cnt == LAST_STEP) nxt = is_div ? S_FIX : S_DONE;
        S_FIX:   nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign busy_n = (nxt == S_LOAD) || (nxt == S_STEP) || (nxt == S_FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      exc_q          <= 1'b0;
      reg_en         <= 1'b0;
      reg_sel        <= SEL_HOLD;
      is_div         <= 1'b0;
      busy           <= 1'b0;
      step_cnt       <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      state          <= nxt;
      exc_q          <= nxt_exc;
      busy           <= busy_n;
      reg_en         <= busy_n;
      is_div         <= nxt_div & busy_n;
      data_resultRDY <= (nxt == S_DONE);
      data_exception <= (nxt == S_DONE) & nxt_exc;
      case (nxt)
        S_LOAD:  reg_sel <= SEL_LOAD;
        S_STEP:  reg_sel <= SEL_STEP;
        S_FIX:   reg_sel <= SEL_FIX;
        default: reg_sel <= SEL_HOLD;
      endcase
      if (nxt == S_LOAD)
        step_cnt <= '0;
      else if (state == S_STEP && !start && step_cnt < MAX_CNT)
        step_cnt <= step_cnt + 6'd1;
    end
  end

  // ALU op follows the live register bits, so it is decoded combinationally.
  always_comb begin
    alu_op = OP_PASS;
    case (state)
      S_STEP: begin
        if (is_div)
          alu_op = rem_neg ? OP_ADD : OP_SUB;
        else if (booth_bits == 2'b01)
          alu_op = OP_ADD;
        else if (booth_bits == 2'b10)
          alu_op = OP_SUB;
        else
          alu_op = OP_PASS;
      end
      S_FIX:   alu_op = rem_neg ? OP_ADD : OP_PASS;
      default: alu_op = OP_PASS;
    endcase
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural model of the 66-bit
// working register and add/sub unit driven by the sequencer outputs.
module tb_multdiv_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctrl_MULT;
  logic       ctrl_DIV;
  logic       divisor_zero;
  logic [1:0] booth_bits;
  logic       rem_neg;
  logic       reg_en;
  logic [1:0] reg_sel;
  logic [1:0] alu_op;
  logic       is_div;
  logic       busy;
  logic [5:0] step_cnt;
  logic       data_resultRDY;
  logic       data_exception;

  int unsigned total = 0;
  int unsigned bad   = 0;

  multdiv_seq #(.STEPS(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .booth_bits     (booth_bits),
    .rem_neg        (rem_neg),
    .reg_en         (reg_en),
    .reg_sel        (reg_sel),
    .alu_op         (alu_op),
    .is_div         (is_div),
    .busy           (busy),
    .step_cnt       (step_cnt),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clk = ~clk;

  // Datapath model: acc is the 33-bit upper part, q the 32-bit lower part.
  logic signed [32:0] acc = '0;
  logic [31:0]        q   = '0;
  logic               qm1 = 1'b0;
  logic [31:0]        op_a = '0;
  logic [31:0]        op_b = '0;
  logic               force_en = 1'b0;
  logic [1:0]         force_bits = 2'b00;

  function automatic logic signed [32:0] alu(input logic [1:0] op,
                                             input logic signed [32:0] x,
                                             input logic signed [32:0] y);
    case (op)
      2'b01:   return x + y;
      2'b10:   return x - y;
      default: return x;
    endcase
  endfunction

  always @(posedge clk) begin : dp
    logic signed [32:0] s;
    logic signed [32:0] m;
    logic signed [32:0] d;
    m = {op_a[31], op_a};
    d = {1'b0, op_b};
    if (reg_en) begin
      case (reg_sel)
        2'b01: begin
          acc <= '0;
          q   <= is_div ? op_a : op_b;
          qm1 <= 1'b0;
        end
        2'b10: begin
          if (!is_div) begin
            s = alu(alu_op, acc, m);
            acc <= s >>> 1;
            q   <= {s[0], q[31:1]};
            qm1 <= q[0];
          end else begin
            s = alu(alu_op, {acc[31:0], q[31]}, d);
            acc <= s;
            q   <= {q[30:0], ~s[32]};
          end
        end
        2'b11: acc <= alu(alu_op, acc, d);
        default: ;
      endcase
    end
  end

  assign booth_bits = force_en ? force_bits : {q[0], qm1};
  assign rem_neg    = acc[32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] outs();
    return {reg_en, reg_sel, alu_op, is_div, busy, step_cnt, data_resultRDY, data_exception};
  endfunction

  int n_err, n_rdy, rdy_cyc, cnt_max, fix_cyc, load_cyc;
  logic exc_at_rdy;
  logic [63:0] res_at_rdy;
  logic [31:0] rem_at_rdy;

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b1; ctrl_DIV = 1'b0; divisor_zero = 1'b0;
    tick(); tick();
    chk("reset_outs", 64'(outs()), 64'h0);
    reset = 1'b0; ctrl_MULT = 1'b0;
    tick();
    chk("idle_outs", 64'(outs()), 64'h0);

    // Multiply 7 x -3
    op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    ctrl_MULT = 1'b1; tick(); ctrl_MULT = 1'b0;
    chk("mul_load_cnt", 64'(step_cnt), 64'd0);
    n_err = 0; n_rdy = 0; rdy_cyc = 0; cnt_max = 0; exc_at_rdy = 1'b1; res_at_rdy = '0;
    for (int i = 1; i <= 40; i++) begin
      if (reg_en !== (i <= 33)) n_err++;
      if (int'(step_cnt) > cnt_max) cnt_max = int'(step_cnt);
      if (data_resultRDY) begin
        n_rdy++; rdy_cyc = i; exc_at_rdy = data_exception;
        res_at_rdy = {acc[31:0], q};
      end
      tick();
    end
    chk("mul_en_window", 64'(n_err), 64'd0);
    chk("mul_cnt_max", 64'(cnt_max), 64'd32);
    chk("mul_cnt_hold", 64'(step_cnt), 64'd32);
    chk("mul_rdy_count", 64'(n_rdy), 64'd1);
    chk("mul_rdy_cycle", 64'(rdy_cyc), 64'd34);
    chk("mul_product", res_at_rdy, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_exc", 64'(exc_at_rdy), 64'd0);

    // Divide 100 / 7
    op_a = 32'd100; op_b = 32'd7;
    ctrl_DIV = 1'b1; tick(); ctrl_DIV = 1'b0;
    n_err = 0; n_rdy = 0; rdy_cyc = 0; fix_cyc = 0; exc_at_rdy = 1'b1;
    res_at_rdy = '0; rem_at_rdy = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 34 && is_div !== 1'b1) n_err++;
      if (reg_en && reg_sel == 2'b11) fix_cyc = i;
      if (data_resultRDY) begin
        n_rdy++; rdy_cyc = i; exc_at_rdy = data_exception;
        res_at_rdy = 64'(q); rem_at_rdy = acc[31:0];
      end
      tick();
    end
    chk("div_isdiv", 64'(n_err), 64'd0);
    chk("div_fix_cycle", 64'(fix_cyc), 64'd34);
    chk("div_rdy_count", 64'(n_rdy), 64'd1);
    chk("div_rdy_cycle", 64'(rdy_cyc), 64'd35);
    chk("div_quot", res_at_rdy, 64'd14);
    chk("div_rem", 64'(rem_at_rdy), 64'd2);
    chk("div_exc", 64'(exc_at_rdy), 64'd0);

    // Divide by zero
    divisor_zero = 1'b1; ctrl_DIV = 1'b1; tick(); ctrl_DIV = 1'b0; divisor_zero = 1'b0;
    chk("dz_rdy_exc", 64'({data_resultRDY, data_exception}), 64'h3);
    n_err = 0;
    for (int i = 1; i <= 6; i++) begin
      if (reg_en) n_err++;
      if (i == 2) chk("dz_idle", 64'({busy, data_resultRDY, data_exception, reg_sel}), 64'h0);
      tick();
    end
    chk("dz_no_en", 64'(n_err), 64'd0);

    // Restart: multiply at cycle 0, divide at cycle 10
    op_a = 32'd100; op_b = 32'd7;
    ctrl_MULT = 1'b1; tick(); ctrl_MULT = 1'b0;
    n_rdy = 0; rdy_cyc = 0; load_cyc = 0; res_at_rdy = '0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) chk("rs_cnt_before", 64'(step_cnt), 64'd8);
      if (i == 11) chk("rs_cnt_restart", 64'(step_cnt), 64'd0);
      if (i > 1 && reg_en && reg_sel == 2'b01) load_cyc = i;
      if (data_resultRDY) begin
        n_rdy++; rdy_cyc = i; res_at_rdy = 64'(q);
      end
      if (i == 10) ctrl_DIV = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
    end
    chk("rs_load_cycle", 64'(load_cyc), 64'd11);
    chk("rs_rdy_count", 64'(n_rdy), 64'd1);
    chk("rs_rdy_cycle", 64'(rdy_cyc), 64'd45);
    chk("rs_quot", res_at_rdy, 64'd14);

    // Reset in the middle of a multiply
    op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    ctrl_MULT = 1'b1; tick(); ctrl_MULT = 1'b0;
    n_err = 0; n_rdy = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i >= 16 && outs() !== 15'h0) n_err++;
      if (data_resultRDY) n_rdy++;
      if (i == 15) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    chk("rst_mid_outs", 64'(n_err), 64'd0);
    chk("rst_mid_rdy", 64'(n_rdy), 64'd0);

    // Booth decode with forced register bits during STEP
    ctrl_MULT = 1'b1; tick(); ctrl_MULT = 1'b0;
    tick();
    chk("booth_sel", 64'({busy, reg_sel}), 64'h6);
    force_en = 1'b1;
    force_bits = 2'b01; #1 chk("booth_01", 64'(alu_op), 64'h1);
    force_bits = 2'b10; #1 chk("booth_10", 64'(alu_op), 64'h2);
    force_bits = 2'b00; #1 chk("booth_00", 64'(alu_op), 64'h0);
    force_bits = 2'b11; #1 chk("booth_11", 64'(alu_op), 64'h0);
    force_en = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
